// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: FSM states, timeout default,
// and the decoded-instruction enums the execute stage hands over.
package load_store_unit_pkg;

    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RESP,
        S_DONE
    } lsu_state_t;

    typedef enum logic [1:0] {
        INSTR_NONE,
        INSTR_LW,
        INSTR_SW
    } instruction_set_t;

    typedef enum logic [1:0] {
        ENC_R,
        ENC_I,
        ENC_S
    } encoding_type_t;

    // A request is only meaningful when exactly one op select is raised.
    function automatic logic op_valid(input logic ld, input logic st);
        return ld ^ st;
    endfunction

endpackage

// File: rtl/lsu_timeout_counter.sv
// 8-bit wait counter: clears on state entry, counts while waiting,
// flags the last permitted cycle so the FSM can abort on the next edge.
module lsu_timeout_counter
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] cnt;

    // Count waiting cycles; hold at the limit rather than wrap.
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= 8'd0;
        else if (clr)
            cnt <= 8'd0;
        else if (inc && !expired)
            cnt <= cnt + 8'd1;
    end

    // cnt holds the number of full waiting cycles already spent, so the
    // TIMEOUT-th waiting cycle is the one where cnt == TIMEOUT-1.
    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding LW/SW unit between the execute stage and a
// req/gnt + rvalid memory port. Misaligned requests and memory stalls
// longer than TIMEOUT cycles complete with err instead of hanging.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata_out,
    output logic [4:0]  rd_out,
    output logic        wb_en,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    lsu_state_t state;
    logic       op_load;
    logic       misal;
    logic       accept;
    logic       cnt_clr;
    logic       cnt_inc;
    logic       expired;

    assign accept = (state == S_IDLE) && start && op_valid(is_load, is_store);

    // Counter restarts on every entry into a waiting state.
    assign cnt_clr = accept ||
                     ((state == S_REQ) && !misal && mem_gnt && op_load);
    assign cnt_inc = (state == S_REQ) || (state == S_WAIT_RESP);

    lsu_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .expired (expired)
    );

    // Main FSM; every port output is registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            wb_en     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            rdata_out <= 32'd0;
            rd_out    <= 5'd0;
            op_load   <= 1'b0;
            misal     <= 1'b0;
        end else begin
            done  <= 1'b0;
            err   <= 1'b0;
            wb_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        // Misaligned requests still spend one cycle in REQ
                        // (with the bus idle) so error latency matches a store.
                        state     <= S_REQ;
                        busy      <= 1'b1;
                        mem_addr  <= addr;
                        mem_wdata <= wdata;
                        rd_out    <= rd;
                        op_load   <= is_load;
                        misal     <= (addr[1:0] != 2'b00);
                        mem_req   <= (addr[1:0] == 2'b00);
                        mem_we    <= (addr[1:0] == 2'b00) && is_store;
                    end
                end
                S_REQ: begin
                    if (misal) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else if (mem_gnt) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (op_load) begin
                            state <= S_WAIT_RESP;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end else if (expired) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= S_DONE;
                        done    <= 1'b1;
                        err     <= 1'b1;
                    end
                end
                S_WAIT_RESP: begin
                    if (mem_rvalid) begin
                        rdata_out <= mem_rdata;
                        state     <= S_DONE;
                        done      <= 1'b1;
                        wb_en     <= 1'b1;
                    end else if (expired) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
